// File: rtl/spram_pkg.sv
// Shared types, masks and helpers for the SP256K initiator.
package spram_pkg;

   localparam int unsigned AW_WORD = 14;
   localparam int unsigned DW      = 16;

   localparam logic [3:0] MASK_LO  = 4'b0011;
   localparam logic [3:0] MASK_HI  = 4'b1100;
   localparam logic [3:0] MASK_ALL = 4'b1111;

   typedef enum logic [1:0] {
      StActive,
      StStandby,
      StWake
   } state_e;

   // Read shadow carried alongside the SPRAM latency.
   typedef struct packed {
      logic valid;
      logic wide;
      logic lane;
   } shadow_t;

   function automatic logic [3:0] write_mask(input logic wide, input logic lane);
      if (wide) return MASK_ALL;
      return lane ? MASK_HI : MASK_LO;
   endfunction

   function automatic logic [DW-1:0] read_select(input logic [DW-1:0] word, input shadow_t sh);
      if (sh.wide) return word;
      return {8'h00, sh.lane ? word[15:8] : word[7:0]};
   endfunction

endpackage

// File: rtl/spram_idle_timer.sv
// Saturating idle counter that flags standby entry, plus the wake-up down-counter.
module spram_idle_timer
   import spram_pkg::*;
#(
   parameter int unsigned IDLE_TIMEOUT = 1024,
   parameter int unsigned WAKE_CYCLES  = 3
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_idle_cycle,
   input  logic i_clear,
   input  logic i_wake_load,
   input  logic i_wake_run,
   output logic o_timeout,
   output logic o_wake_done
);

   localparam int unsigned CW = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);
   localparam int unsigned WW = 4;

   logic [CW-1:0] r_idle_cnt;
   logic [WW-1:0] r_wake_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idle_cnt <= '0;
         r_wake_cnt <= '0;
      end else begin
         if (i_clear) begin
            r_idle_cnt <= '0;
         end else if (i_idle_cycle && (IDLE_TIMEOUT != 0) &&
                      (r_idle_cnt != CW'(IDLE_TIMEOUT))) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
         end

         if (i_wake_load) begin
            r_wake_cnt <= WW'(WAKE_CYCLES);
         end else if (i_wake_run && (r_wake_cnt != '0)) begin
            r_wake_cnt <= r_wake_cnt - 1'b1;
         end
      end
   end

   // Strobe on the idle cycle that brings the count up to the timeout.
   assign o_timeout   = i_idle_cycle && (IDLE_TIMEOUT != 0) &&
                        (r_idle_cnt == CW'(IDLE_TIMEOUT - 32'd1));
   assign o_wake_done = i_wake_run && (r_wake_cnt <= WW'(1));

endmodule

// File: rtl/spram_initiator.sv
// Byte/word request port to SP256K command translator with in-order reads and standby control.
module spram_initiator
   import spram_pkg::*;
#(
   parameter int unsigned IDLE_TIMEOUT = 1024,
   parameter int unsigned WAKE_CYCLES  = 3
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic               i_req_write,
   input  logic               i_req_wide,
   input  logic [AW_WORD:0]   i_req_addr,
   input  logic [DW-1:0]      i_req_wdata,
   output logic               o_rsp_valid,
   output logic [DW-1:0]      o_rsp_rdata,
   output logic [AW_WORD-1:0] o_ram_ad,
   output logic [DW-1:0]      o_ram_di,
   input  logic [DW-1:0]      i_ram_do,
   output logic [3:0]         o_ram_maskwe,
   output logic               o_ram_we,
   output logic               o_ram_cs,
   output logic               o_ram_stdby,
   output logic               o_ram_sleep,
   output logic               o_ram_pwroff_n,
   output logic               o_idle
);

   state_e  r_state;
   shadow_t r_p1;
   shadow_t r_p2;
   shadow_t w_shadow;
   logic    w_accept;
   logic    w_pipe_busy;
   logic    w_timeout;
   logic    w_wake_done;

   assign o_req_ready = (r_state == StActive);
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_pipe_busy = r_p1.valid || r_p2.valid;
   assign w_shadow    = '{valid: w_accept && !i_req_write, wide: i_req_wide, lane: i_req_addr[0]};

   assign o_ram_sleep    = 1'b0;
   assign o_ram_pwroff_n = 1'b1;
   assign o_idle         = (r_state == StActive) && !w_pipe_busy;

   spram_idle_timer #(
      .IDLE_TIMEOUT (IDLE_TIMEOUT),
      .WAKE_CYCLES  (WAKE_CYCLES)
   ) u_idle_timer (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_idle_cycle ((r_state == StActive) && !w_accept && !w_pipe_busy),
      .i_clear      (w_accept || (r_state != StActive)),
      .i_wake_load  ((r_state == StStandby) && i_req_valid),
      .i_wake_run   (r_state == StWake),
      .o_timeout    (w_timeout),
      .o_wake_done  (w_wake_done)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= StActive;
         o_ram_ad     <= '0;
         o_ram_di     <= '0;
         o_ram_maskwe <= '0;
         o_ram_we     <= 1'b0;
         o_ram_cs     <= 1'b0;
         o_ram_stdby  <= 1'b0;
         o_rsp_valid  <= 1'b0;
         o_rsp_rdata  <= '0;
         r_p1         <= '0;
         r_p2         <= '0;
      end else begin
         o_ram_cs     <= w_accept;
         o_ram_we     <= w_accept && i_req_write;
         o_ram_maskwe <= (w_accept && i_req_write) ? write_mask(i_req_wide, i_req_addr[0]) : '0;
         if (w_accept) begin
            o_ram_ad <= i_req_addr[AW_WORD:1];
         end
         if (w_accept && i_req_write) begin
            o_ram_di <= i_req_wide ? i_req_wdata : {2{i_req_wdata[7:0]}};
         end

         // ram_do for a p2 read is valid now; capture it into the response.
         r_p1        <= w_shadow;
         r_p2        <= r_p1;
         o_rsp_valid <= r_p2.valid;
         if (r_p2.valid) begin
            o_rsp_rdata <= read_select(i_ram_do, r_p2);
         end

         unique case (r_state)
            StActive: begin
               if (w_timeout) begin
                  r_state     <= StStandby;
                  o_ram_stdby <= 1'b1;
               end
            end
            StStandby: begin
               if (i_req_valid) begin
                  r_state     <= StWake;
                  o_ram_stdby <= 1'b0;
               end
            end
            StWake: begin
               if (w_wake_done) begin
                  r_state <= StActive;
               end
            end
            default: r_state <= StActive;
         endcase
      end
   end

endmodule

// File: doc/spram_initiator.md
Name: spram_initiator

Overview:
- Initiator/controller driving one SP256K single-port RAM instance (16K x 16) on behalf of a byte/word request port.
- Converts byte-addressed 8-bit or 16-bit requests into SPRAM commands with nibble write masks.
- Tracks the fixed SPRAM read latency and returns in-order read responses.
- Manages standby power: enters STDBY after an idle timeout and wakes on demand.

Parameters:
- IDLE_TIMEOUT, 1024: idle cycles (no accepted request, nothing in flight) before standby entry; 0 disables standby.
- WAKE_CYCLES, 3: cycles with ram_stdby low before the first command after standby exit; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present; must be held with stable payload until accepted
- req_ready  out  1  request accepted on a cycle with req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_wide  in  1  1 = 16-bit access (req_addr[0] ignored), 0 = byte access
- req_addr  in  15  byte address: [14:1] word index, [0] byte lane (1 = high byte)
- req_wdata  in  16  write data; byte writes use [7:0]
- rsp_valid  out  1  one-cycle pulse per accepted read
- rsp_rdata  out  16  read data; byte reads zero-extended
- ram_ad  out  14  to SP256K AD
- ram_di  out  16  to SP256K DI
- ram_do  in  16  from SP256K DO
- ram_maskwe  out  4  to SP256K MASKWE
- ram_we  out  1  to SP256K WE
- ram_cs  out  1  to SP256K CS
- ram_stdby  out  1  to SP256K STDBY
- ram_sleep  out  1  constant 0
- ram_pwroff_n  out  1  constant 1
- idle  out  1  high in ACTIVE with no read in flight

Behaviour:
- States: ACTIVE, STANDBY, WAKE. Reset enters ACTIVE.
- Reset values of registered outputs: ram_* = 0, rsp_valid = 0, rsp_rdata = 0. Idle counter and the in-flight pipeline are cleared, so an in-flight read is dropped with no response.
- req_ready is 1 only in ACTIVE. It is combinational from state, so it is 1 in the first cycle after reset.
- Accept on edge E0:
  - Registered ram_cs=1, ram_ad=addr[14:1], ram_we=write are driven during the cycle after E0; SPRAM samples them at E1.
  - Byte write: ram_di = {wdata[7:0], wdata[7:0]}; ram_maskwe = 4'b0011 (lane 0) or 4'b1100 (lane 1).
  - Wide write: ram_di = wdata, ram_maskwe = 4'b1111.
  - Reads: ram_maskwe = 0, ram_we = 0.
- Cycles with no accept: ram_cs=0 and ram_we=0; ram_ad and ram_di hold their values.
- Throughput: one request per cycle, back to back, any read/write mix.
- Read latency: ram_do is valid after E1, is captured at E2, and rsp_valid is high in the cycle after E2 (2 cycles after accept).
  - Responses are strictly in request order.
  - A 2-stage shadow pipe carries {valid, wide, lane}.
  - Byte read returns {8'h00, lane ? ram_do[15:8] : ram_do[7:0]}.
- Writes produce no response. A read issued the cycle after a write to the same word returns the new data.
- Idle counter:
  - Counts cycles in ACTIVE with no accept and an empty read pipe.
  - Clears on any accept.
  - When it reaches IDLE_TIMEOUT (non-zero): move to STANDBY, register ram_stdby=1, keep ram_cs=0.
  - Saturates; never wraps.
- STANDBY: ram_stdby=1, req_ready=0. When req_valid is seen, move to WAKE and register ram_stdby=0.
- WAKE: req_ready=0. A down-counter loaded with WAKE_CYCLES returns to ACTIVE when it reaches 0. The held request is accepted in the first ACTIVE cycle.
- A request arriving in the same cycle the counter hits the timeout: the accept wins and standby is not entered.
- Reset in STANDBY or WAKE: ram_stdby drops to 0 on the reset edge; state returns to ACTIVE.

Decomposition:
- spram_pkg holds:
  - state enum (ACTIVE/STANDBY/WAKE)
  - MASK_LO=4'b0011, MASK_HI=4'b1100, MASK_ALL=4'b1111
  - widths AW_WORD=14, DW=16
- One sub-module, spram_idle_timer: the saturating idle counter plus the wake down-counter, with a timeout strobe and a wake_done strobe.
- Everything else lives in spram_initiator.

Test Plan:
- Wide write 0xBEEF to byte addr 0x0010, then wide read of 0x0010 -> ram_maskwe=4'b1111, ram_ad=0x0008; rsp_valid 2 cycles after read accept with rsp_rdata=0xBEEF.
- Byte write 0x5A to addr 0x0021, then wide read of 0x0020 after the word was preloaded with 0x1234 -> ram_maskwe=4'b1100, ram_di=0x5A5A, rsp_rdata=0x5A34; byte read of 0x0020 -> 0x0034.
- Four back-to-back reads of words 0..3 holding 0x0000..0x0003 -> req_ready stays 1; rsp_valid on four consecutive cycles, data 0,1,2,3 in order.
- IDLE_TIMEOUT=8, WAKE_CYCLES=3, no traffic -> ram_stdby=1 after 8 idle cycles. A read then asserted -> req_ready low for 1 + 3 cycles; the read is accepted afterwards with correct data.
- rst asserted one cycle after a read accept -> no rsp_valid ever for that read; all ram_* = 0 the cycle after reset; req_ready=1.
- IDLE_TIMEOUT=0 with 5000 idle cycles -> ram_stdby never asserts.
